// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator scheduler.
// - estado_t : scheduler state encoding (2 bits)
// - SOBE / DESCE : values of the direction output
// - N_ANDARES / ANDAR_W : floor count and floor index width
// - mascaraAcima / mascaraAbaixo : floor masks strictly above / below a floor
package elevador_pkg;

  localparam int N_ANDARES = 4;
  localparam int ANDAR_W   = 2;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VIAJANDO = 2'd1,
    CHEGADA  = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  function automatic logic [N_ANDARES-1:0] mascaraAcima(input logic [ANDAR_W-1:0] a);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (i > int'(a)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [N_ANDARES-1:0] mascaraAbaixo(input logic [ANDAR_W-1:0] a);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (i < int'(a)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/temporizador_carga.sv
// Loadable down-counter shared by travel pacing and the door timer.
// - clock, reset_n : clock and asynchronous active-low reset (count clears to 0)
// - load, valor    : load valor on the next edge (load wins over counting)
// - zero           : count is 0; the counter holds at 0 until reloaded
module temporizador_carga #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= valor;
    end else if (contagem != '0) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/escalonador_elevador.sv
// Elevator request scheduler with collective (SCAN) direction choice.
// - clock, reset_n          : clock, asynchronous active-low reset
// - pedido                  : call buttons (level, one per floor)
// - andar                   : mirror of the current floor
// - controleSubidaDescida   : travel direction, 1 = up, 0 = down
// - passo                   : one-cycle floor-step strobe for the floor datapath
// - movendo                 : high in VIAJANDO or CHEGADA
// - porta_aberta            : high in PORTA
// - pedidos                 : latched pending requests
// - estado                  : scheduler state, exposed for debug/checkers
module escalonador_elevador
  import elevador_pkg::*;
#(
  parameter int T_VIAGEM = 4,
  parameter int T_PORTA  = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_ANDARES-1:0] pedido,
  output logic [ANDAR_W-1:0]   andar,
  output logic                 controleSubidaDescida,
  output logic                 passo,
  output logic                 movendo,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pedidos,
  output estado_t              estado
);

  localparam int T_MAX = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] CARGA_VIAGEM = TW'(T_VIAGEM - 1);
  localparam logic [TW-1:0] CARGA_PORTA  = TW'(T_PORTA - 1);

  logic                 timerZero;
  logic                 carregar;
  logic [TW-1:0]        valorCarga;
  estado_t              estadoProx;
  logic                 dirProx;
  logic [N_ANDARES-1:0] bitAndar;
  logic                 acima;
  logic                 abaixo;
  logic                 chamadaAqui;
  logic                 botaoAqui;
  logic                 aFrente;
  logic                 atras;

  temporizador_carga #(.W(TW)) u_temporizador (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (carregar),
    .valor   (valorCarga),
    .zero    (timerZero)
  );

  assign bitAndar    = {{(N_ANDARES-1){1'b0}}, 1'b1} << andar;
  // acima/abaixo look only at latched requests, which is what keeps passo
  // from ever stepping past floor 0 or the top floor.
  assign acima       = |(pedidos & mascaraAcima(andar));
  assign abaixo      = |(pedidos & mascaraAbaixo(andar));
  assign botaoAqui   = |(pedido & bitAndar);
  assign chamadaAqui = |(pedidos & bitAndar) | botaoAqui;
  assign aFrente     = (controleSubidaDescida == SOBE) ? acima : abaixo;
  assign atras       = (controleSubidaDescida == SOBE) ? abaixo : acima;

  assign passo        = (estado == VIAJANDO) && timerZero;
  assign movendo      = (estado == VIAJANDO) || (estado == CHEGADA);
  assign porta_aberta = (estado == PORTA);

  always_comb begin
    estadoProx = estado;
    dirProx    = controleSubidaDescida;
    carregar   = 1'b0;
    valorCarga = CARGA_VIAGEM;
    case (estado)
      OCIOSO: begin
        if (chamadaAqui) begin
          estadoProx = PORTA;
          carregar   = 1'b1;
          valorCarga = CARGA_PORTA;
        end else if (acima || abaixo) begin
          estadoProx = VIAJANDO;
          carregar   = 1'b1;
          // keep going the same way while that side has work, else turn around
          dirProx    = aFrente ? controleSubidaDescida : ~controleSubidaDescida;
        end
      end
      VIAJANDO: begin
        if (timerZero) estadoProx = CHEGADA;
      end
      CHEGADA: begin
        if (chamadaAqui) begin
          estadoProx = PORTA;
          carregar   = 1'b1;
          valorCarga = CARGA_PORTA;
        end else if (aFrente) begin
          estadoProx = VIAJANDO;
          carregar   = 1'b1;
        end else begin
          // direction flips even when nothing is pending behind us
          dirProx = ~controleSubidaDescida;
          if (atras) begin
            estadoProx = VIAJANDO;
            carregar   = 1'b1;
          end else begin
            estadoProx = OCIOSO;
          end
        end
      end
      PORTA: begin
        if (botaoAqui) begin
          carregar   = 1'b1;
          valorCarga = CARGA_PORTA;
        end else if (timerZero) begin
          estadoProx = OCIOSO;
        end
      end
      default: estadoProx = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado                <= OCIOSO;
      controleSubidaDescida <= SOBE;
      andar                 <= '0;
      pedidos               <= '0;
    end else begin
      estado                <= estadoProx;
      controleSubidaDescida <= dirProx;
      if (passo) begin
        andar <= (controleSubidaDescida == SOBE) ? andar + 1'b1 : andar - 1'b1;
      end
      // the floor being served is never latched while its door is open
      if (estado == PORTA) pedidos <= (pedidos | pedido) & ~bitAndar;
      else                 pedidos <= pedidos | pedido;
    end
  end

endmodule
